alu_op_issuer: RTL

//   Issue stage on the operand/control side of the 4-bit-opcode ALU. Accepts decoded

---
 rtl/alu_op_issuer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issue stage between decode and writeback for the 4-bit-opcode ALU.
// Registers operands and the encoded ALU operation, then captures the ALU result,
// zero flag, branch decision and illegal flag and presents them downstream.
// One transaction in flight; accept -> exec -> done, at most one every 3 cycles.
// Optional build macro ALU_ISSUER_STATS_EN adds OP_COUNT, a wrapping 32-bit count
// of completed transactions, including illegal ones.
//
// state | meaning
// IDLE  | ready for a new transaction
// EXEC  | operands and operation driven into the ALU; result captured on exit
// DONE  | result presented downstream, held until OUT_READY
module alu_op_issuer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       ALU_OP,
  input  logic [2:0]       FUNCT3,
  input  logic             FUNCT7_5,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       ALU_OPERATION,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic             ZERO,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO_OUT,
  output logic             BRANCH_TAKEN,
  output logic             ILLEGAL
`ifdef ALU_ISSUER_STATS_EN
  ,
  output logic [31:0]      OP_COUNT
`endif
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_ILL = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] enc_op;
  logic       enc_illegal;
  logic [1:0] alu_op_q;
  logic [2:0] funct3_q;
  logic       illegal_q;
  logic       accept;

  assign accept = IN_VALID & IN_READY;

  // Decode instruction fields into the ALU operation code; unsupported combos map to 1111.
  always_comb begin
    enc_op      = OP_ADD;
    enc_illegal = 1'b0;
    unique case (ALU_OP)
      2'b00: enc_op = OP_ADD;
      2'b01: begin
        enc_op = OP_SUB;
        if (FUNCT3 != 3'b000 && FUNCT3 != 3'b001) enc_illegal = 1'b1;
      end
      2'b10: begin
        unique case (FUNCT3)
          3'b000:  enc_op = FUNCT7_5 ? OP_SUB : OP_ADD;
          3'b111:  enc_op = OP_AND;
          3'b110:  enc_op = OP_OR;
          default: enc_illegal = 1'b1;
        endcase
      end
      default: begin
        unique case (FUNCT3)
          3'b000:  enc_op = OP_ADD;
          3'b111:  enc_op = OP_AND;
          3'b110:  enc_op = OP_OR;
          default: enc_illegal = 1'b1;
        endcase
      end
    endcase
    if (enc_illegal) enc_op = OP_ILL;
  end

  // State register; reset returns to IDLE from anywhere, dropping any transaction.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (state_q)
      IDLE: begin
        IN_READY = ~RST;
        if (IN_VALID && !RST) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/operation capture on accept; these stay put until the next accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      A             <= '0;
      B             <= '0;
      ALU_OPERATION <= 4'b0000;
      alu_op_q      <= 2'b00;
      funct3_q      <= 3'b000;
      illegal_q     <= 1'b0;
    end else if (accept) begin
      A             <= SRC_A;
      B             <= SRC_B;
      ALU_OPERATION <= enc_op;
      alu_op_q      <= ALU_OP;
      funct3_q      <= FUNCT3;
      illegal_q     <= enc_illegal;
    end
  end

  // Result/flag capture at the end of EXEC; illegal ops force all-ones and clear flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RESULT       <= '0;
      ZERO_OUT     <= 1'b0;
      BRANCH_TAKEN <= 1'b0;
      ILLEGAL      <= 1'b0;
    end else if (state_q == EXEC) begin
      RESULT       <= illegal_q ? '1 : ALU_RESULT;
      ZERO_OUT     <= ~illegal_q & ZERO;
      BRANCH_TAKEN <= ~illegal_q & (alu_op_q == 2'b01) &
                      (((funct3_q == 3'b000) & ZERO) | ((funct3_q == 3'b001) & ~ZERO));
      ILLEGAL      <= illegal_q;
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  // Completed-transaction counter; wraps naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (RST)                    OP_COUNT <= '0;
    else if (OUT_VALID && OUT_READY) OP_COUNT <= OP_COUNT + 32'd1;
  end
`endif

endmodule
